// File: rtl/sys_ctrl_regfile.sv
// Host command controller in front of the register file: decodes UART write/read frames.
// Optional write acknowledge byte enabled by defining SYS_CTRL_WR_ACK_EN.
module sys_ctrl_regfile #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = 'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = 'hBB
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  TX_BUSY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
`ifdef SYS_CTRL_WR_ACK_EN
        , ACK_SEND
`endif
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n, txd_n;
    logic                  wr_n, rd_n, vld_n;
    logic                  bad_q, bad_n;
    logic                  cap_q, cap_n;
    logic                  addr_ok;

    assign addr_ok = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            bad_q     <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            state     <= state_n;
            Address   <= addr_n;
            WrData    <= wdata_n;
            TX_P_DATA <= txd_n;
            WrEn      <= wr_n;
            RdEn      <= rd_n;
            TX_D_VLD  <= vld_n;
            bad_q     <= bad_n;
            cap_q     <= cap_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = Address;
        wdata_n = WrData;
        txd_n   = TX_P_DATA;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        vld_n   = 1'b0;
        bad_n   = bad_q;
        cap_n   = cap_q;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)      state_n = WR_ADDR;
                    else if (RX_P_DATA == CMD_RD) state_n = RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    // an out-of-range write still consumes its data byte
                    bad_n = !addr_ok;
                    if (addr_ok) addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    if (!bad_q) begin
                        wdata_n = RX_P_DATA;
                        wr_n    = 1'b1;
                    end
`ifdef SYS_CTRL_WR_ACK_EN
                    txd_n   = bad_q ? DATA_WIDTH'(8'hEE) : DATA_WIDTH'(8'h55);
                    state_n = ACK_SEND;
`else
                    state_n = IDLE;
`endif
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                        rd_n    = 1'b1;
                        state_n = RD_WAIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                cap_n   = 1'b1;
                state_n = TX_SEND;
            end
            TX_SEND: begin
                // RdData is valid on the first TX_SEND cycle; capture it exactly once
                if (cap_q) begin
                    txd_n = RdData;
                    cap_n = 1'b0;
                end
                if (!TX_BUSY) begin
                    vld_n   = 1'b1;
                    state_n = IDLE;
                end
            end
`ifdef SYS_CTRL_WR_ACK_EN
            ACK_SEND: begin
                if (!TX_BUSY) begin
                    vld_n   = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule
